i2s_rx_sequencer: RTL and testbench

- Receive-side sequencer for the I2S microphone bus, in the same clk_in domain as the I2S clock/word-select generator.
- Watches sck/ws from that generator and samples sd_in on sck rising edges.
- Frames left/right slots, assembles MSB-first samples and hands them downstream through a 2-entry valid/ready output queue.
- Flags overruns and framing errors.

---
 rtl/i2s_rx_sequencer.sv | 112 +++++++++++
 tb/tb_i2s_rx_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sequencer.sv
// i2s_rx_sequencer: frames I2S slots, assembles MSB-first samples into a 2-entry valid/ready queue.
// Define I2S_RX_RIGHT_CHANNEL_EN to queue right-slot words as well as left.
module i2s_rx_sequencer #(
  parameter int SAMPLE_WIDTH  = 18,
  parameter int SLOT_BITS     = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     sck_in,
  input  logic                     ws_in,
  input  logic                     sd_in,
  output logic [SAMPLE_WIDTH-1:0]  sample_out,
  output logic                     channel_out,
  output logic                     sample_valid_out,
  input  logic                     sample_ready_in,
  output logic                     overrun_out,
  output logic                     framing_err_out,
  output logic [ERR_CNT_WIDTH-1:0] overrun_count_out
);
  localparam int CW = $clog2(SLOT_BITS);
`ifdef I2S_RX_RIGHT_CHANNEL_EN
  localparam int EW = SAMPLE_WIDTH + 1;
`else
  localparam int EW = SAMPLE_WIDTH;
`endif
  typedef enum logic [1:0] {SYNC, SHIFT, DRAIN} state_t;
  state_t                  state;
  logic                    sck_prev, ws_prev, chan, push_req;
  logic [CW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [EW-1:0]           q0, q1, entry;
  logic [1:0]              q_cnt;
  logic                    rise, ws_edge, pop, push;
  assign rise             = sck_in & ~sck_prev;
  assign ws_edge          = rise & (ws_in != ws_prev);
  assign sample_valid_out = q_cnt != 2'd0;
  assign pop              = sample_valid_out & sample_ready_in;
  assign push             = push_req & ((q_cnt != 2'd2) | pop);
  assign overrun_out      = push_req & ~push;
  assign sample_out       = q0[SAMPLE_WIDTH-1:0];
`ifdef I2S_RX_RIGHT_CHANNEL_EN
  assign entry       = {chan, shift_reg};
  assign channel_out = q0[SAMPLE_WIDTH];
`else
  assign entry       = shift_reg;
  assign channel_out = 1'b0;
`endif
  // The bit on a ws-edge rise belongs to the previous word (one-bit delay), so it is never shifted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= SYNC;
      sck_prev        <= 1'b0;
      ws_prev         <= 1'b0;
      chan            <= 1'b0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      push_req        <= 1'b0;
      framing_err_out <= 1'b0;
    end else begin
      sck_prev        <= sck_in;
      push_req        <= 1'b0;
      framing_err_out <= 1'b0;
      if (rise) begin
        ws_prev <= ws_in;
        if (ws_edge) begin
          state           <= SHIFT;
          chan            <= ws_in;
          bit_cnt         <= '0;
          framing_err_out <= state == SHIFT;
        end else if (state == SHIFT) begin
          shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], sd_in};
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(SAMPLE_WIDTH - 1)) begin
            state <= DRAIN;
`ifdef I2S_RX_RIGHT_CHANNEL_EN
            push_req <= 1'b1;
`else
            push_req <= ~chan;
`endif
          end
        end
      end
    end
  end
  // q0 is the head; q1 only holds data when two entries are queued.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      q0                <= '0;
      q1                <= '0;
      q_cnt             <= 2'd0;
      overrun_count_out <= '0;
    end else begin
      if (pop & push) begin
        if (q_cnt == 2'd2) begin
          q0 <= q1;
          q1 <= entry;
        end else begin
          q0 <= entry;
        end
      end else if (pop) begin
        q0    <= q1;
        q_cnt <= q_cnt - 2'd1;
      end else if (push) begin
        if (q_cnt == 2'd0) q0 <= entry;
        else q1 <= entry;
        q_cnt <= q_cnt + 2'd1;
      end
      if (overrun_out && !(&overrun_count_out)) overrun_count_out <= overrun_count_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// tb_i2s_rx_sequencer: directed slot vectors plus overrun, framing and reset sequences.
module tb_i2s_rx_sequencer;
  localparam int SW = 18;
`ifdef I2S_RX_RIGHT_CHANNEL_EN
  localparam bit REN = 1'b1;
`else
  localparam bit REN = 1'b0;
`endif
  typedef struct {
    logic          w;
    int            n;
    logic [SW-1:0] d;
    bit            emit;
  } vec_t;
  logic clk = 0, rst = 1, sck = 0, ws = 0, sd = 0, ready = 0;
  logic [SW-1:0] sample;
  logic ch, valid, ovr, ferr;
  logic [7:0] ocnt;
  int n_cmp = 0, n_bad = 0, fe_cnt = 0, ov_cnt = 0, fe0, ov0;
  logic [SW:0] got[$];
  logic v1, v2, o1, lv1, lv2, lo1, cw, wj;
  vec_t tbl[7];
  i2s_rx_sequencer dut (
    .clk_in(clk), .rst_in(rst), .sck_in(sck), .ws_in(ws), .sd_in(sd),
    .sample_out(sample), .channel_out(ch), .sample_valid_out(valid),
    .sample_ready_in(ready), .overrun_out(ovr), .framing_err_out(ferr),
    .overrun_count_out(ocnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ferr) fe_cnt++;
    if (ovr) ov_cnt++;
    if (valid && ready) got.push_back({ch, sample});
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // One sck period of 3 clk: rise cycle, high, low. Starts and ends 2 time units after a posedge.
  task automatic sbit(input logic w, input logic d);
    sck = 1; ws = w; sd = d;
    @(negedge clk);
    @(negedge clk);
    v1 = valid; o1 = ovr;
    @(posedge clk); #2 sck = 0;
    @(negedge clk);
    v2 = valid;
    @(posedge clk); #2;
  endtask
  task automatic send_slot(input logic w, input logic [SW-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sbit(w, (i >= 1 && i <= SW) ? d[SW-i] : 1'b0);
      if (i == SW) begin lv1 = v1; lv2 = v2; lo1 = o1; end
    end
  endtask
  task automatic take(input string nm, input logic [SW-1:0] d, input logic c);
    logic [SW:0] e;
    chk({nm, " avail"}, got.size() > 0, 1);
    if (got.size() > 0) begin
      e = got.pop_front();
      chk({nm, " data"}, e[SW-1:0], d);
      chk({nm, " ch"}, e[SW], c);
    end
  endtask
  initial begin
    tbl[0] = '{1'b0, 10, 18'h11111, 1'b0};
    tbl[1] = '{1'b1, 32, 18'h15432, REN};
    tbl[2] = '{1'b0, 32, 18'h2ABCD, 1'b1};
    tbl[3] = '{1'b1, 32, 18'h15432, REN};
    tbl[4] = '{1'b0, 32, 18'h00000, 1'b1};
    tbl[5] = '{1'b1, 32, 18'h3FFFF, REN};
    tbl[6] = '{1'b0, 32, 18'h20000, 1'b1};
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst valid", valid, 0);
    chk("rst sample", sample, 0);
    chk("rst ch", ch, 0);
    chk("rst ovr", ovr, 0);
    chk("rst ferr", ferr, 0);
    chk("rst ocnt", ocnt, 0);
    @(posedge clk); #2 rst = 0; ready = 1;
    for (int k = 0; k < 7; k++) begin
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_slot(tbl[k].w, tbl[k].d, tbl[k].n);
      chk($sformatf("v%0d count", k), got.size(), tbl[k].emit);
      if (tbl[k].emit) begin
        take($sformatf("v%0d", k), tbl[k].d, tbl[k].w);
        chk($sformatf("v%0d valid t+1", k), lv1, 0);
        chk($sformatf("v%0d valid t+2", k), lv2, 1);
      end
      chk($sformatf("v%0d ferr", k), fe_cnt - fe0, 0);
      chk($sformatf("v%0d ovr", k), ov_cnt - ov0, 0);
    end
    ready = 0; ov0 = ov_cnt;
    for (int j = 1; j <= 3; j++) begin
      wj = REN ? (j % 2 == 1) : 1'b0;
      if (!REN) send_slot(1'b1, 18'h3FFFF, 32);
      if (j == 3) chk("ovr before", ov_cnt - ov0, 0);
      send_slot(wj, SW'(j), 32);
    end
    chk("ovr pulse", lo1, 1);
    chk("ovr once", ov_cnt - ov0, 1);
    chk("ocnt", ocnt, 1);
    chk("stall valid", valid, 1);
    chk("stall data", sample, 1);
    chk("stall ch", ch, REN);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall data hold", sample, 1);
    chk("stall none out", got.size(), 0);
    @(posedge clk); #2 ready = 1;
    repeat (4) @(posedge clk);
    #2;
    take("pop1", 18'h00001, REN);
    take("pop2", 18'h00002, 1'b0);
    chk("drained", valid, 0);
    cw = REN;
    fe0 = fe_cnt;
    send_slot(~cw, 18'h2AAAA, 11);
    chk("frm none yet", fe_cnt - fe0, 0);
    send_slot(cw, 18'h3FFFF, 32);
    chk("frm pulse", fe_cnt - fe0, 1);
    chk("frm count", got.size(), 1);
    take("frm", 18'h3FFFF, cw);
    if (cw == 1'b0) send_slot(1'b1, 18'h3FFFF, 32);
    got.delete();
    ready = 0;
    send_slot(1'b0, 18'h0AAAA, 32);
    send_slot(1'b1, 18'h15432, 32);
    send_slot(1'b0, 18'h05555, 8);
    chk("pre-rst valid", valid, 1);
    chk("pre-rst ocnt", ocnt, 1);
    rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("post-rst valid", valid, 0);
    chk("post-rst ocnt", ocnt, 0);
    @(posedge clk); #2 ready = 1;
    send_slot(1'b0, 18'h1F1F1, 24);
    chk("post-rst quiet", got.size(), 0);
    send_slot(1'b1, 18'h12345, 32);
    send_slot(1'b0, 18'h0F0F0, 32);
    chk("post-rst count", got.size(), REN ? 2 : 1);
    if (REN) take("post-rst r", 18'h12345, 1'b1);
    take("post-rst l", 18'h0F0F0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
